ofm_wb_ctrl: RTL
================

Name: ofm_wb_ctrl

Overview:
- Write-back controller between the PE output lanes (each already registered through an OFM output buffer stage) and the OFM memory.
- Round-robin arbitrates NUM_LANES requesting output-channel lanes onto the single OFM memory write port.
- Generates planar addresses: one channel plane per lane.
- Sequences one tile per start pulse and reports completion.

Parameters:
- NUM_LANES, 4, number of PE output lanes / output channels per tile; must be ≥ 2.
- DATA_W, 8, signed OFM element width.
- ADDR_W, 16, OFM memory word address width.
- DIM_W, 8, width of the tile height/width configuration fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; accepted only in IDLE.
- cfg_ofm_w  in  DIM_W  tile width in pixels, 1..255; sampled on accepted start.
- cfg_ofm_h  in  DIM_W  tile height in pixels, 1..255; sampled on accepted start.
- cfg_base_addr  in  ADDR_W  address of lane 0 plane, element 0; sampled on accepted start.
- lane_valid  in  NUM_LANES  per-lane data valid.
- lane_data  in  NUM_LANES*DATA_W  packed signed data; lane i occupies bits [i*DATA_W +: DATA_W].
- lane_ready  out  NUM_LANES  one-hot-or-zero grant; combinational from state, arbiter pointer and lane_valid.
- mem_we  out  1  OFM memory write enable.
- mem_addr  out  ADDR_W  OFM memory write address.
- mem_wdata  out  DATA_W  OFM memory write data.
- busy  out  1  high in LOAD and RUN.
- done  out  1  single-cycle pulse when the tile completes.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; lane_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0; all lane counters=0; RR pointer=0.
- FSM: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 latches cfg_ofm_w, cfg_ofm_h and cfg_base_addr, clears all counters, goes to LOAD.
  - start is ignored in every other state.
- LOAD (1 cycle): registers plane_size = w*h (2*DIM_W bits, zero-extended/truncated to ADDR_W), then goes to RUN.
- RUN:
  - A lane is eligible when lane_valid[i]=1 and cnt[i] < plane_size.
  - Grant goes to the first eligible lane searching from ptr, ptr+1, … (mod NUM_LANES); lane_ready is one-hot on that lane.
  - Handshake = lane_valid[i] & lane_ready[i].
  - On handshake (registered, 1-cycle latency): mem_we=1, mem_addr = base + i*plane_size + cnt[i] (mod 2^ADDR_W), mem_wdata = lane_data[i]; cnt[i]++; ptr = i+1 mod NUM_LANES.
  - No handshake: mem_we=0 next cycle; ptr unchanged; mem_addr/mem_wdata hold their previous values.
  - Finished lanes (cnt = plane_size) get lane_ready=0 forever in this tile; their lane_valid is ignored.
  - When the handshake that brings the last lane to plane_size occurs, the next state is DONE.
- DONE (1 cycle):
  - done=1, lane_ready=0.
  - mem_we=1 in this cycle for the final write, because of the registered output stage.
  - Then IDLE.
- Throughput: one element per cycle whenever any lane is eligible; no bubbles between different lanes.
- Fairness: with all lanes continuously valid, the grant sequence is 0,1,2,3,0,…
- Boundary cases:
  - w=h=1: each lane writes exactly once; done follows 1 cycle after the final handshake.
  - lane_valid dropping mid-tile only stalls that lane.
  - A lane raising valid after finishing is never granted.
  - rst asserted mid-RUN: everything returns to reset values next cycle; no further writes; done is not asserted.
  - Address overflow wraps silently.
  - Signed data passes through unmodified; no saturation in this block.

Decomposition:
- Package ofm_pkg holds:
  - the state enum typedef (IDLE, LOAD, RUN, DONE);
  - localparams for DATA_W and the default NUM_LANES.
- One sub-module, rr_arbiter: parameter N; inputs req[N] and ptr; output grant one-hot; purely combinational.
- The pointer register lives in ofm_wb_ctrl.

Test Plan:
1. Reset then idle: hold rst 2 cycles with lane_valid=4'hF -> lane_ready=0, mem_we=0, busy=0 throughout; start asserted together with rst is ignored.
2. Basic tile: w=2, h=1, base=0x0100, lanes always valid with data lane*16+cnt.
   - Required grant order: 0,1,2,3,0,1,2,3.
   - Required writes: 0x100/0x00, 0x102/0x10, 0x104/0x20, 0x106/0x30, 0x101/0x01, 0x103/0x11, 0x105/0x21, 0x107/0x31.
   - done one cycle after the 8th handshake.
3. Sparse valid: only lane 2 valid, w=h=1 -> one write to base+2*1.
   - Then raise lanes 0, 1, 3 one at a time; each is written once.
   - done after the 4th write; lane 2 is not re-granted.
4. Negative data and stall: lane 1 sends 0x80 (-128) and 0xFF with 3 idle cycles between them -> mem_wdata 0x80 then 0xFF; mem_we low during the gap; addresses consecutive.
5. Reset mid-tile: w=h=4, rst after 5 writes -> next cycle all outputs at reset values; a new start then rewrites from base with cnt=0.
6. Address wrap: base=0xFFFE, w=h=2 -> lane 0 writes 0xFFFE, 0xFFFF, 0x0000, 0x0001; lane 1 writes starting at 0x0002.

Source files
------------

// File: rtl/ofm_pkg.sv
// Shared types and defaults for the OFM write-back path.
package ofm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_LANES = 4;

endpackage

// File: rtl/ofm_wb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import ofm_pkg::*;
#(
  parameter int N = DEF_NUM_LANES
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ofm_wb_ctrl.sv
// OFM write-back controller: arbitrates PE output lanes onto one memory
// write port, one channel plane per lane, one tile per start pulse.
module ofm_wb_ctrl
  import ofm_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = 16,
  parameter int DIM_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DIM_W-1:0]            cfg_ofm_w,
  input  logic [DIM_W-1:0]            cfg_ofm_h,
  input  logic [ADDR_W-1:0]           cfg_base_addr,
  input  logic [NUM_LANES-1:0]        lane_valid,
  input  logic [NUM_LANES*DATA_W-1:0] lane_data,
  output logic [NUM_LANES-1:0]        lane_ready,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        busy,
  output logic                        done
);

  localparam int PW = $clog2(NUM_LANES);

  state_t               state;
  logic [DIM_W-1:0]     ofm_w;
  logic [DIM_W-1:0]     ofm_h;
  logic [ADDR_W-1:0]    base_addr;
  logic [ADDR_W-1:0]    plane_size;
  logic [ADDR_W-1:0]    cnt [NUM_LANES];
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        gidx;
  logic [NUM_LANES-1:0] req;
  logic [NUM_LANES-1:0] grant;
  logic [2*DIM_W-1:0]   area;
  logic                 hs;
  logic                 last_hs;

  assign area = ofm_w * ofm_h;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_LANES; i++)
      req[i] = (state == RUN) && lane_valid[i] && (cnt[i] < plane_size);
  end

  rr_arbiter #(.N(NUM_LANES)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (grant)
  );

  assign lane_ready = grant;
  assign hs         = |grant;
  assign busy       = (state == LOAD) || (state == RUN);

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (grant[i]) gidx = PW'(i);
  end

  // The tile ends on the handshake after which every lane sits at plane_size.
  always_comb begin
    last_hs = hs;
    for (int j = 0; j < NUM_LANES; j++) begin
      if (PW'(j) == gidx) begin
        if (cnt[j] + ADDR_W'(1) != plane_size) last_hs = 1'b0;
      end else if (cnt[j] != plane_size) begin
        last_hs = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ofm_w      <= '0;
      ofm_h      <= '0;
      base_addr  <= '0;
      plane_size <= '0;
      ptr        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) cnt[i] <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ofm_w     <= cfg_ofm_w;
            ofm_h     <= cfg_ofm_h;
            base_addr <= cfg_base_addr;
            for (int i = 0; i < NUM_LANES; i++) cnt[i] <= '0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          plane_size <= ADDR_W'(area);
          state      <= RUN;
        end
        RUN: begin
          if (hs) begin
            mem_we    <= 1'b1;
            mem_addr  <= base_addr + ADDR_W'(gidx) * plane_size + cnt[gidx];
            mem_wdata <= lane_data[gidx*DATA_W +: DATA_W];
            cnt[gidx] <= cnt[gidx] + ADDR_W'(1);
            ptr       <= (gidx == PW'(NUM_LANES - 1)) ? '0 : gidx + PW'(1);
            // done rides alongside the final registered write in DONE.
            if (last_hs) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
